mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (IF) and data load/store (D).

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority, with a starvation bound so fetch always makes progress.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  err
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        F_BUSY,
        D_BUSY,
        RESP
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   to_cnt;

    assign stall = if_req & ~if_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end
                    // Data wins unless fetch has already waited out its starvation budget.
                    if (d_req && (!if_req || starve_cnt < STARVE_LIM)) begin
                        state     <= D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        to_cnt    <= '0;
                        if (if_req) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (if_req) begin
                        state      <= F_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        to_cnt     <= '0;
                        starve_cnt <= '0;
                    end
                end
                F_BUSY, D_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (state == D_BUSY) begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Memory never answered: abort and hand back zero data with err.
                        mem_req <= 1'b0;
                        state   <= RESP;
                        err     <= 1'b1;
                        if (state == D_BUSY) begin
                            d_ready <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    if_rdata <= '0;
                    d_rdata  <= '0;
                    err      <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder, a transaction-level reference
// model checked every cycle, and hand-computed expectations for each scenario.
module tb_mem_arbiter;

    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 64;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_STARVE(MAX_STARVE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ready(if_ready),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .stall(stall),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                                 input logic we, input logic [31:0] da, input logic [31:0] dw);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = we;
        d_addr  = da;
        d_wdata = dw;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks in the ack_delay-th cycle of mem_req (0 = never).
    logic [31:0] mem_array [logic [31:0]];
    int  ack_delay  = 1;
    int  req_cycles = 0;
    bit  late_ack   = 0;

    function automatic logic [31:0] memValue(input logic [31:0] a);
        if (mem_array.exists(a)) return mem_array[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A_5A5A;
            late_ack  = 0;
        end else if (mem_req) begin
            req_cycles++;
            if (ack_delay != 0 && req_cycles == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_rdata = 32'hFFFF_FFFF;
                    mem_array[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = memValue(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end else begin
            req_cycles = 0;
            mem_ack    = 1'b0;
            mem_rdata  = 32'hBAD0_BAD0;
        end
    end

    // Reference model: one transaction in flight at most, ready one cycle after ack or timeout.
    bit          in_flight = 0;
    bit          resp_due  = 0;
    bit          t_d, t_we, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;
    int          busy   = 0;
    int          starve = 0;
    bit          prev_mem_req = 0;
    logic [31:0] grant_log[$];

    always @(negedge clk) begin
        logic exp_ifr, exp_dr, exp_err;
        exp_ifr = 1'b0;
        exp_dr  = 1'b0;
        exp_err = 1'b0;
        if (!rst) begin
            checkOutput("rst_mem_req", mem_req, 0);
            checkOutput("rst_mem_addr", mem_addr, 0);
            checkOutput("rst_if_ready", if_ready, 0);
            checkOutput("rst_d_ready", d_ready, 0);
            checkOutput("rst_err", err, 0);
            checkOutput("rst_stall", stall, if_req);
            in_flight = 0;
            resp_due  = 0;
            starve    = 0;
        end else begin
            if (resp_due) begin
                checkOutput("model_mem_req_resp", mem_req, 0);
                exp_err = t_err;
                if (t_d) begin
                    exp_dr = 1'b1;
                    checkOutput("model_d_rdata", d_rdata, t_rdata);
                end else begin
                    exp_ifr = 1'b1;
                    checkOutput("model_if_rdata", if_rdata, t_rdata);
                end
                resp_due = 0;
            end else if (in_flight) begin
                checkOutput("model_mem_req_busy", mem_req, 1);
                checkOutput("model_mem_we", mem_we, t_we);
                checkOutput("model_mem_addr", mem_addr, t_addr);
                checkOutput("model_mem_wdata", mem_wdata, t_wdata);
                busy++;
                if (mem_ack) begin
                    t_rdata   = (t_d && t_we) ? 32'h0 : mem_rdata;
                    t_err     = 0;
                    resp_due  = 1;
                    in_flight = 0;
                end else if (busy == TIMEOUT) begin
                    t_rdata   = 32'h0;
                    t_err     = 1;
                    resp_due  = 1;
                    in_flight = 0;
                end
            end else begin
                checkOutput("model_mem_req_idle", mem_req, 0);
                if (!if_req) starve = 0;
                if (d_req && (!if_req || starve < MAX_STARVE)) begin
                    t_d = 1; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata;
                    if (if_req) starve = (starve + 1 > MAX_STARVE) ? MAX_STARVE : starve + 1;
                    in_flight = 1;
                    busy = 0;
                end else if (if_req) begin
                    t_d = 0; t_we = 0; t_addr = if_addr; t_wdata = 32'h0;
                    starve = 0;
                    in_flight = 1;
                    busy = 0;
                end
            end
            checkOutput("model_if_ready", if_ready, exp_ifr);
            checkOutput("model_d_ready", d_ready, exp_dr);
            checkOutput("model_err", err, exp_err);
            checkOutput("model_stall", stall, if_req & ~exp_ifr);
        end
        if (mem_req && !prev_mem_req) grant_log.push_back(mem_addr);
        prev_mem_req = mem_req;
    end

    task automatic waitReady(input bit want_d, input int limit, output int cycles,
                             output int mreq_cycles, output int stall_low, output int other_ready);
        bit seen;
        seen = 0;
        cycles = 0; mreq_cycles = 0; stall_low = 0; other_ready = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (want_d ? d_ready : if_ready) begin
                seen = 1;
            end else begin
                if (mem_req) mreq_cycles++;
                if (!stall) stall_low++;
                if (want_d ? if_ready : d_ready) other_ready++;
            end
        end
        checkOutput("ready_seen", seen, 1);
    endtask

    initial begin
        int cyc, mrc, sl, oth;
        logic [31:0] exp_order [5];
        exp_order = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h1000};

        rst = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        if_req = 1'b1;
        #1;
        checkOutput("reset_stall_follows_if_req", stall, 1);
        if_req = 1'b0;
        nextCycle();
        rst = 1'b1;
        nextCycle();

        $display("[TB] load alone");
        mem_array[32'h40] = 32'hDEAD_BEEF;
        ack_delay = 2;
        applyStimulus(0, 0, 1, 0, 32'h40, 0);
        waitReady(1, 20, cyc, mrc, sl, oth);
        checkOutput("t1_latency", cyc - 1, 3);
        checkOutput("t1_d_rdata", d_rdata, 32'hDEAD_BEEF);
        checkOutput("t1_err", err, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();

        $display("[TB] starvation bound");
        grant_log.delete();
        ack_delay = 1;
        applyStimulus(1, 32'h1000, 1, 0, 32'h200, 0);
        waitReady(0, 100, cyc, mrc, sl, oth);
        checkOutput("t2_stall_low_cycles", sl, 0);
        checkOutput("t2_if_rdata", if_rdata, 32'hA5A5_1000);
        checkOutput("t2_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2_grant%0d", i), grant_log[i], exp_order[i]);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();

        $display("[TB] store");
        ack_delay = 3;
        applyStimulus(0, 0, 1, 1, 32'h100, 32'h1234_5678);
        repeat (2) nextCycle();
        checkOutput("t3_mem_req", mem_req, 1);
        checkOutput("t3_mem_we", mem_we, 1);
        checkOutput("t3_mem_addr", mem_addr, 32'h100);
        checkOutput("t3_mem_wdata", mem_wdata, 32'h1234_5678);
        waitReady(1, 20, cyc, mrc, sl, oth);
        checkOutput("t3_d_rdata", d_rdata, 0);
        checkOutput("t3_err", err, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();

        $display("[TB] timeout abort");
        ack_delay = 0;
        applyStimulus(1, 32'h300, 0, 0, 0, 0);
        waitReady(0, 100, cyc, mrc, sl, oth);
        checkOutput("t4_mem_req_cycles", mrc, 64);
        checkOutput("t4_err", err, 1);
        checkOutput("t4_if_rdata", if_rdata, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        late_ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4_late_if_ready", if_ready, 0);
            checkOutput("t4_late_err", err, 0);
            checkOutput("t4_late_mem_req", mem_req, 0);
        end
        nextCycle();

        $display("[TB] reset during data transaction");
        ack_delay = 0;
        applyStimulus(1, 32'h500, 1, 0, 32'h400, 0);
        repeat (3) nextCycle();
        #2;
        checkOutput("t5_busy_mem_req", mem_req, 1);
        checkOutput("t5_busy_mem_addr", mem_addr, 32'h400);
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_mem_req", mem_req, 0);
        checkOutput("t5_rst_d_ready", d_ready, 0);
        applyStimulus(1, 32'h500, 0, 0, 0, 0);
        grant_log.delete();
        nextCycle();
        ack_delay = 1;
        rst = 1'b1;
        waitReady(0, 20, cyc, mrc, sl, oth);
        checkOutput("t5_first_grant", grant_log[0], 32'h500);
        checkOutput("t5_no_d_ready", oth, 0);
        checkOutput("t5_if_rdata", if_rdata, 32'hA5A5_0500);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();

        $display("[TB] slow ack with dropped fetch request");
        ack_delay = 10;
        applyStimulus(1, 32'h600, 0, 0, 0, 0);
        repeat (3) nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitReady(0, 30, cyc, mrc, sl, oth);
        checkOutput("t6_if_rdata", if_rdata, 32'hA5A5_0600);
        @(negedge clk);
        checkOutput("t6_idle_mem_req", mem_req, 0);
        checkOutput("t6_single_pulse", if_ready, 0);
        @(negedge clk);
        checkOutput("t6_still_idle", if_ready, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
